// File: rtl/icache_miss_responder.sv
// Memory-side I-cache miss responder: queues miss requests and fetches each line word-by-word in FIFO order.
// Latency: line valid the cycle after its last data word; miss2mem stalls when full, the line is held until accepted.
module icache_miss_responder #(
  parameter int BA_BITS         = 7,
  parameter int WID_BITS        = 2,
  parameter int FIFO_DEPTH      = 4,
  parameter int FIFO_DEPTH_BITS = 2,
  parameter int WORDS_PER_LINE  = 4,
  parameter int WORD_IDX_BITS   = 2,
  parameter int WORD_BITS       = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                miss2mem_valid_i,
  output logic                                miss2mem_ready_o,
  input  logic [BA_BITS-1:0]                  miss2mem_block_addr_i,
  input  logic [WID_BITS-1:0]                 miss2mem_instr_id_i,
  output logic                                mem_rd_req_valid_o,
  input  logic                                mem_rd_req_ready_i,
  output logic [BA_BITS+WORD_IDX_BITS-1:0]    mem_rd_req_addr_o,
  input  logic                                mem_rd_rsp_valid_i,
  input  logic [WORD_BITS-1:0]                mem_rd_rsp_data_i,
  output logic                                miss_rsp_valid_o,
  input  logic                                miss_rsp_ready_i,
  output logic [BA_BITS-1:0]                  miss_rsp_block_addr_o,
  output logic [WID_BITS-1:0]                 miss_rsp_instr_id_o,
  output logic [WORDS_PER_LINE*WORD_BITS-1:0] miss_rsp_data_o
);

  localparam int CW = WORD_IDX_BITS + 1;
  localparam logic [CW-1:0] LP_WORDS   = CW'(WORDS_PER_LINE);
  localparam logic [CW-1:0] LP_LAST    = CW'(WORDS_PER_LINE - 1);
  localparam logic [CW-1:0] LP_CNT_ONE = CW'(1);
  localparam logic [FIFO_DEPTH_BITS-1:0] LP_PTR_ONE = FIFO_DEPTH_BITS'(1);
  localparam logic [FIFO_DEPTH_BITS:0]   LP_DEPTH   = (FIFO_DEPTH_BITS+1)'(FIFO_DEPTH);
  localparam logic [FIFO_DEPTH_BITS:0]   LP_FCNT_ONE = (FIFO_DEPTH_BITS+1)'(1);

  typedef struct packed {
    logic [BA_BITS-1:0]  block_addr;
    logic [WID_BITS-1:0] instr_id;
  } req_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  req_t                       r_fifo [FIFO_DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_BITS-1:0] r_rd_ptr;
  logic [FIFO_DEPTH_BITS:0]   r_count;
  logic [CW-1:0]              r_issue_cnt;
  logic [CW-1:0]              r_recv_cnt;
  logic [WORD_BITS-1:0]       r_buf [WORDS_PER_LINE];

  req_t w_push_dat;
  req_t w_head;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_issue_fire;
  logic w_recv_en;
  logic w_cnt_clr;

  // Ready is held low while reset is asserted so no request is accepted into a cleared queue.
  assign w_full           = (r_count == LP_DEPTH);
  assign w_empty          = (r_count == '0);
  assign miss2mem_ready_o = rst_n && !w_full;
  assign w_push           = miss2mem_valid_i && miss2mem_ready_o;
  assign w_pop            = miss_rsp_valid_o && miss_rsp_ready_i;
  assign w_push_dat       = {miss2mem_block_addr_i, miss2mem_instr_id_i};
  assign w_head           = r_fifo[r_rd_ptr];
  assign w_issue_fire     = mem_rd_req_valid_o && mem_rd_req_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_push_dat;
        r_wr_ptr         <= r_wr_ptr + LP_PTR_ONE;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_FCNT_ONE;
        2'b01:   r_count <= r_count - LP_FCNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt           = r_state;
    w_cnt_clr             = 1'b0;
    w_recv_en             = 1'b0;
    mem_rd_req_valid_o    = 1'b0;
    mem_rd_req_addr_o     = '0;
    miss_rsp_valid_o      = 1'b0;
    miss_rsp_block_addr_o = '0;
    miss_rsp_instr_id_o   = '0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = S_FETCH;
          w_cnt_clr   = 1'b1;
        end
      end
      S_FETCH: begin
        mem_rd_req_valid_o = (r_issue_cnt < LP_WORDS);
        mem_rd_req_addr_o  = {w_head.block_addr, r_issue_cnt[WORD_IDX_BITS-1:0]};
        w_recv_en          = mem_rd_rsp_valid_i && (r_recv_cnt < LP_WORDS);
        if (mem_rd_rsp_valid_i && (r_recv_cnt == LP_LAST)) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        miss_rsp_valid_o      = 1'b1;
        miss_rsp_block_addr_o = w_head.block_addr;
        miss_rsp_instr_id_o   = w_head.instr_id;
        if (miss_rsp_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else if (w_cnt_clr) begin
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else begin
      if (w_issue_fire) r_issue_cnt <= r_issue_cnt + LP_CNT_ONE;
      if (w_recv_en)    r_recv_cnt  <= r_recv_cnt + LP_CNT_ONE;
    end
  end

  // Only FETCH writes the line, so stray responses in IDLE/RESP cannot corrupt a held line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS_PER_LINE; i++) r_buf[i] <= '0;
    end else if (w_recv_en) begin
      r_buf[r_recv_cnt[WORD_IDX_BITS-1:0]] <= mem_rd_rsp_data_i;
    end
  end

  for (genvar g = 0; g < WORDS_PER_LINE; g++) begin : g_line
    assign miss_rsp_data_o[WORD_BITS*(g+1)-1 -: WORD_BITS] = r_buf[g];
  end

endmodule
